// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and byte-level helpers
// (S-box lookup, xtime, ShiftRows, MixColumns) for the encrypt core.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_BLOCK_W    = 128;
    localparam int AES_RND_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        ROUND,
        DONE
    } aes_fsm_e;

    // FIPS-197 forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte index = row + 4*col; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r] = s[127-8*(4*c+r) -: 8];
            end
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = xtime(a[r])
                                      ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                      ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped
// when last_round) and AddRoundKey. Ports: state, round_key, last_round
// in; next_state out.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] round_key,
    input  logic                   last_round,
    output logic [AES_BLOCK_W-1:0] next_state
);

    logic [AES_BLOCK_W-1:0] sub;
    logic [AES_BLOCK_W-1:0] shifted;

    always_comb begin
        sub = '0;
        for (int i = 0; i < 16; i++) begin
            sub[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
        end
        shifted    = shift_rows(sub);
        next_state = (last_round ? shifted : mix_columns(shifted)) ^ round_key;
    end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption, one round per clock, round keys fetched
// from key_expansion via round_sel/round_key.
// Ports: clk, reset (sync, active high), start, plaintext, key_ready,
// round_sel, round_key, ciphertext, done (1-cycle pulse), busy.
// Build option: define AES_BACK2BACK_EN to accept a new block in DONE.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int RND_W      = AES_RND_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [AES_BLOCK_W-1:0] plaintext,
    input  logic                   key_ready,
    output logic [RND_W-1:0]       round_sel,
    input  logic [AES_BLOCK_W-1:0] round_key,
    output logic [AES_BLOCK_W-1:0] ciphertext,
    output logic                   done,
    output logic                   busy
);

    aes_fsm_e               fsm;
    aes_fsm_e               fsm_next;
    logic [AES_BLOCK_W-1:0] state;
    logic [AES_BLOCK_W-1:0] round_out;
    logic [RND_W-1:0]       rnd;
    logic                   last_round;
    logic                   can_accept;
    logic                   accept;

`ifdef AES_BACK2BACK_EN
    assign can_accept = (fsm == IDLE) || (fsm == DONE);
`else
    assign can_accept = (fsm == IDLE);
`endif

    // Acceptance with keys ready folds round-key 0 into the load.
    assign accept     = can_accept && start && key_ready;
    assign last_round = (rnd == RND_W'(NUM_ROUNDS));

    aes_round_comb u_round (
        .state      (state),
        .round_key  (round_key),
        .last_round (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE: begin
                if (accept) begin
                    fsm_next = ROUND;
                end else if (start) begin
                    fsm_next = WAIT_KEY;
                end
            end
            WAIT_KEY: if (key_ready) fsm_next = ROUND;
            ROUND:    if (last_round) fsm_next = DONE;
            DONE:     fsm_next = accept ? ROUND : IDLE;
            default:  fsm_next = IDLE;
        endcase
    end

    always_comb begin
        round_sel = (fsm == ROUND) ? rnd : '0;
        busy      = (fsm != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= '0;
            rnd        <= '0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= plaintext ^ round_key;
                rnd   <= RND_W'(1);
            end else begin
                case (fsm)
                    IDLE: if (start) state <= plaintext;
                    WAIT_KEY: begin
                        if (key_ready) begin
                            state <= state ^ round_key;
                            rnd   <= RND_W'(1);
                        end
                    end
                    ROUND: begin
                        if (last_round) begin
                            ciphertext <= round_out;
                            done       <= 1'b1;
                        end else begin
                            state <= round_out;
                            rnd   <= rnd + RND_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Randomized and known-answer bench for aes_encrypt_core; models
// key_expansion and AES-128 with GF(2^8) arithmetic on byte arrays.
module tb_aes_encrypt_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] plaintext;
    logic         key_ready;
    logic [3:0]   round_sel;
    logic [127:0] round_key;
    logic [127:0] ciphertext;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [0:10];

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    always #5 clk = ~clk;

    // Keys are only meaningful while key_ready; otherwise drive junk.
    assign round_key = !key_ready ? 128'hdeadbeef_0badf00d_cafebabe_5a5a5a5a
                     : (round_sel <= 4'd10) ? rk[round_sel] : '0;

    aes_encrypt_core dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key_ready  (key_ready),
        .round_sel  (round_sel),
        .round_key  (round_key),
        .ciphertext (ciphertext),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            t = {1'b0, a} * 9'd2;
            if (t > 9'd255) t ^= 9'h11b;
            a = t[7:0];
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from multiplicative inverse plus affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w+4*c] = s[w+4*((c+w)%4)];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    s[w+4*c] = (r == 10) ? t[w+4*c]
                             : gmul(8'h02, t[4*c+w]) ^ gmul(8'h03, t[4*c+(w+1)%4])
                             ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
            for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept a block, then count cycles (acceptance cycle = 0) to done.
    task automatic run_block(input logic [127:0] pt, output int lat,
                             output logic [127:0] ct);
        start     = 1'b1;
        plaintext = pt;
        tick();
        start     = 1'b0;
        plaintext = rand128();
        chk("busy_run", 128'(busy), 128'd1);
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        ct = ciphertext;
        tick();
        chk("done_pulse", 128'(done), 128'd0);
    endtask

    initial begin
        int           lat;
        int           n;
        int           d1;
        int           d2;
        logic [127:0] ct;
        logic [127:0] ct1;
        logic [127:0] pt;

        reset     = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        key_ready = 1'b1;
        build_sbox();
        set_key(KEY1);
        tick();
        tick();
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ct", ciphertext, 128'd0);
        chk("rst_rsel", 128'(round_sel), 128'd0);
        reset = 1'b0;
        tick();

        run_block(PT1, lat, ct);
        chk("kat1_ct", ct, CT1);
        chk("kat1_lat", 128'(lat), 128'd11);
        chk("kat1_model", model_enc(PT1), CT1);

        set_key('0);
        run_block('0, lat, ct);
        chk("kat2_ct", ct, CT0);

        for (int i = 0; i < 8; i++) begin
            set_key(rand128());
            pt = rand128();
            run_block(pt, lat, ct);
            chk("rand_ct", ct, model_enc(pt));
            chk("rand_lat", 128'(lat), 128'd11);
        end

        set_key(KEY1);
        key_ready = 1'b0;
        start     = 1'b1;
        plaintext = PT1;
        tick();
        start     = 1'b0;
        plaintext = rand128();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy && !done) n++;
            tick();
        end
        chk("wait_busy", 128'(n), 128'd5);
        key_ready = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("wait_lat", 128'(lat), 128'd11);
        chk("wait_ct", ciphertext, CT1);
        tick();

        start     = 1'b1;
        plaintext = PT1;
        tick();
        start = 1'b0;
        n  = 0;
        d1 = 0;
        for (int i = 2; i <= 25; i++) begin
            start     = (i == 5);
            plaintext = (i == 5) ? rand128() : plaintext;
            tick();
            if (done) begin
                n++;
                d1 = i;
            end
        end
        start = 1'b0;
        chk("busy_start_dones", 128'(n), 128'd1);
        chk("busy_start_lat", 128'(d1), 128'd11);
        chk("busy_start_ct", ciphertext, CT1);

        set_key('0);
        run_block('0, lat, ct);
        set_key(KEY1);
        start     = 1'b1;
        plaintext = PT1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_done", 128'(done), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_ct", ciphertext, 128'd0);
        chk("mid_rst_rsel", 128'(round_sel), 128'd0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) n++;
        end
        chk("mid_rst_nodone", 128'(n), 128'd0);
        run_block(PT1, lat, ct);
        chk("post_rst_ct", ct, CT1);
        chk("post_rst_lat", 128'(lat), 128'd11);

        start     = 1'b1;
        plaintext = PT1;
        tick();
        plaintext = '0;
        d1  = 0;
        d2  = 0;
        ct1 = '0;
        lat = 1;
        while (d2 == 0 && lat < 60) begin
            if (done) begin
                if (d1 == 0) begin
                    d1  = lat;
                    ct1 = ciphertext;
                end else begin
                    d2 = lat;
                end
            end
            if (d2 == 0) begin
                tick();
                lat++;
            end
        end
        start = 1'b0;
        chk("b2b_ct1", ct1, CT1);
        chk("b2b_ct2", ciphertext, model_enc('0));
`ifdef AES_BACK2BACK_EN
        chk("b2b_gap", 128'(d2 - d1), 128'd11);
`else
        chk("b2b_gap", 128'(d2 - d1), 128'd12);
`endif
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
Iterative AES-128 encryption datapath that consumes the round keys produced by key_expansion.
- Executes one round per clock.
- Reads round keys by driving key_expansion's desired_round with round_sel and sampling its expanded_key on round_key.
- Waits for key_expansion done (key_ready) before starting.
- Returns a registered ciphertext with a one-cycle done pulse.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is supported.
- RND_W, 4, width of round_sel and the internal round counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to encrypt plaintext; single-cycle pulse or level.
- plaintext  in  128  input block; byte 0 at [127:120], column-major per FIPS-197.
- key_ready  in  1  connects to key_expansion done; round keys are valid while high.
- round_sel  out  RND_W  connects to key_expansion desired_round.
- round_key  in  128  connects to key_expansion expanded_key; combinationally valid in the same cycle as round_sel.
- ciphertext  out  128  result block, registered; held until the next result.
- done  out  1  one-cycle pulse; ciphertext is valid from this cycle on.
- busy  out  1  high from acceptance through the done cycle.

Behaviour:
- Reset values: ciphertext 0, done 0, busy 0, round_sel 0, FSM IDLE, state register 0, round counter 0.
- States: IDLE, WAIT_KEY, ROUND, DONE.
- IDLE, start=1, key_ready=1:
  - round_sel=0, so round_key is round key 0.
  - state <= plaintext ^ round_key; rnd <= 1; go to ROUND.
- IDLE, start=1, key_ready=0: latch plaintext into state; go to WAIT_KEY.
- WAIT_KEY:
  - round_sel=0.
  - When key_ready=1: state <= state ^ round_key; rnd <= 1; go to ROUND.
  - start is ignored while in WAIT_KEY.
- ROUND: round_sel=rnd.
  - rnd 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ round_key; rnd <= rnd+1.
  - rnd 10: ciphertext <= ShiftRows(SubBytes(state)) ^ round_key; done <= 1; go to DONE.
- DONE:
  - done=1 for exactly this cycle; round_sel=0.
  - Next state is IDLE, unless AES_BACK2BACK_EN acceptance applies.
- Latency: start accepted in cycle T gives done high in cycle T+11. Without back-to-back, throughput is one block per 12 cycles.
- busy: 0 in IDLE, 1 in WAIT_KEY, ROUND and DONE.
- start while busy (WAIT_KEY or ROUND): ignored, not queued.
- plaintext: sampled only in the accepting cycle; later changes have no effect.
- key_ready falling during ROUND: the core completes anyway. The result is unchecked, and integration must not restart key expansion while busy.
- reset mid-operation: the next cycle is IDLE with all outputs at reset values. No done pulse is issued for the aborted block.
- Arithmetic: GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- round_sel: a pure function of FSM state and rnd; no glitch requirement beyond synchronous design.

Optional Feature:
- Macro: AES_BACK2BACK_EN.
- Defined: in DONE, start=1 with key_ready=1 is accepted exactly as in IDLE (state <= plaintext ^ rk0, go to ROUND, busy stays 1). Throughput is one block per 11 cycles. In that DONE cycle round_sel=0 feeds the AddRoundKey.
- Undefined: start in DONE is ignored; acceptance happens only in IDLE.

Decomposition:
- aes_pkg holds:
  - constants: AES_NUM_ROUNDS=10, AES_BLOCK_W=128, AES_RND_W=4.
  - state enum: IDLE, WAIT_KEY, ROUND, DONE.
  - functions: sbox, xtime, shift_rows, mix_columns.
- Sub-module aes_round_comb (purely combinational):
  - inputs: state, round_key, last_round.
  - output: next_state.
  - function: SubBytes, ShiftRows, MixColumns bypassed when last_round, then AddRoundKey.
- The FSM, counter and registers stay in aes_encrypt_core.

Test Plan:
- Known answer 1: key_expansion with key 000102030405060708090a0b0c0d0e0f, then start with plaintext 00112233445566778899aabbccddeeff. Require ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a and done exactly 11 cycles after acceptance, lasting 1 cycle.
- Known answer 2: key all-zero, plaintext all-zero. Require ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Key not ready: start while key_ready=0 gives busy=1 and a WAIT_KEY hold for 5 cycles. Raise key_ready; require the vector-1 result with done 11 cycles after key_ready rose.
- Start while busy: pulse start with a different plaintext at T+4. Require no effect, the vector-1 ciphertext, and a single done pulse.
- Reset mid-operation: assert reset at T+5. Require done, busy, ciphertext and round_sel at 0 next cycle, and no done pulse. A subsequent vector-1 run must pass.
- Back-to-back: hold start=1 for both blocks, vector 1 then all-zero plaintext.
  - AES_BACK2BACK_EN defined: done pulses 11 cycles apart.
  - Undefined: done pulses 12 cycles apart.
  - Both cases: second ciphertext matches the reference model (C model/known answer) for all-zero plaintext under the 000102..0f key.
